// File: rtl/pairing_result_serializer_if.sv
// Word-stream interface between pairing_result_serializer (master) and a narrow host/bus sink (slave).
// word_sel widens beyond 3 bits only when an element needs more than 8 words (WORD_W = 8 or 16).
interface pairing_result_serializer_if #(
    parameter int WORD_W = 32
);
    localparam int WPE   = (194 + WORD_W - 1) / WORD_W;
    localparam int SEL_W = (WPE > 8) ? $clog2(WPE) : 3;

    logic [WORD_W-1:0] word;
    logic              word_valid;
    logic              word_ready;
    logic              word_last;
    logic [2:0]        word_elem;
    logic [SEL_W-1:0]  word_sel;

    modport master (
        output word,
        output word_valid,
        output word_last,
        output word_elem,
        output word_sel,
        input  word_ready
    );

    modport slave (
        input  word,
        input  word_valid,
        input  word_last,
        input  word_elem,
        input  word_sel,
        output word_ready
    );
endinterface

// File: rtl/pairing_result_serializer.sv
// Captures the 1164-bit GF(3^97) pairing result on a rising done edge and streams it as WORD_W words.
// Optional macro PAIRING_TRIT_CHECK_EN adds a bad_trit flag for illegal 2'b11 trit encodings.
module pairing_result_serializer #(
    parameter int WORD_W = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           done,
    input  logic [1163:0]                  result,
    pairing_result_serializer_if.master    bus,
    output logic                           busy,
    output logic                           overrun
`ifdef PAIRING_TRIT_CHECK_EN
    ,
    output logic                           bad_trit
`endif
);
    localparam int ELEM_W = 194;
    localparam int RES_W  = 6 * ELEM_W;
    localparam int WPE    = (ELEM_W + WORD_W - 1) / WORD_W;
    localparam int NWORDS = 6 * WPE;
    localparam int SEL_W  = (WPE > 8) ? $clog2(WPE) : 3;
    localparam int PAD_W  = WPE * WORD_W;

    localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(WPE - 1);
    localparam logic [2:0]       LAST_ELEM = 3'd5;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t             state_q, state_d;
    logic               done_q, done_d;
    logic [RES_W-1:0]   buf_q, buf_d;
    logic [WORD_W-1:0]  word_q, word_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic [2:0]         elem_q, elem_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               overrun_q, overrun_d;

    logic               rise;
    logic               handshake;
    logic               final_hs;
    logic               capture;
    logic [2:0]         nxt_elem;
    logic [SEL_W-1:0]   nxt_sel;
    logic               nxt_last;

`ifdef PAIRING_TRIT_CHECK_EN
    logic               bad_trit_q, bad_trit_d;
    logic               trit_bad;
`endif

    // Bits of an element above 193 are zero-padded so the top word of each element is partial.
    function automatic logic [WORD_W-1:0] pick_word(
        input logic [RES_W-1:0] src,
        input logic [2:0]       e,
        input logic [SEL_W-1:0] s
    );
        logic [PAD_W-1:0] padded;
        padded = '0;
        padded[ELEM_W-1:0] = src[int'(e) * ELEM_W +: ELEM_W];
        return padded[int'(s) * WORD_W +: WORD_W];
    endfunction

`ifdef PAIRING_TRIT_CHECK_EN
    always_comb begin
        trit_bad = 1'b0;
        for (int i = 0; i < RES_W / 2; i++) begin
            trit_bad = trit_bad | (result[2*i] & result[2*i+1]);
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        done_d    = done;
        buf_d     = buf_q;
        word_d    = word_q;
        valid_d   = valid_q;
        last_d    = last_q;
        elem_d    = elem_q;
        sel_d     = sel_q;
        overrun_d = overrun_q;
`ifdef PAIRING_TRIT_CHECK_EN
        bad_trit_d = bad_trit_q;
`endif

        rise      = done & ~done_q;
        handshake = valid_q & bus.word_ready;
        final_hs  = handshake & last_q;
        capture   = rise & ((state_q == IDLE) | final_hs);

        if (sel_q == LAST_SEL) begin
            nxt_sel  = '0;
            nxt_elem = elem_q + 3'd1;
        end else begin
            nxt_sel  = sel_q + SEL_W'(1);
            nxt_elem = elem_q;
        end
        nxt_last = (nxt_elem == LAST_ELEM) && (nxt_sel == LAST_SEL);

        // A result landing mid-stream is dropped; only the final-handshake cycle can chain it.
        if (rise && (state_q == SEND) && !final_hs) begin
            overrun_d = 1'b1;
        end

        if (capture) begin
            buf_d   = result;
            state_d = SEND;
            valid_d = 1'b1;
            word_d  = result[WORD_W-1:0];
            elem_d  = '0;
            sel_d   = '0;
            last_d  = 1'b0;
`ifdef PAIRING_TRIT_CHECK_EN
            bad_trit_d = trit_bad;
`endif
        end else if (final_hs) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            elem_d  = '0;
            sel_d   = '0;
        end else if (handshake) begin
            elem_d = nxt_elem;
            sel_d  = nxt_sel;
            last_d = nxt_last;
            word_d = pick_word(buf_q, nxt_elem, nxt_sel);
        end
    end

    // done_q tracks done even in reset so a level held across reset release is not seen as an edge.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
        if (!reset) begin
            state_q   <= IDLE;
            done_q    <= done_d;
            word_q    <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            elem_q    <= '0;
            sel_q     <= '0;
            overrun_q <= 1'b0;
`ifdef PAIRING_TRIT_CHECK_EN
            bad_trit_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            elem_q    <= elem_d;
            sel_q     <= sel_d;
            overrun_q <= overrun_d;
`ifdef PAIRING_TRIT_CHECK_EN
            bad_trit_q <= bad_trit_d;
`endif
        end
    end

    assign bus.word       = word_q;
    assign bus.word_valid = valid_q;
    assign bus.word_last  = last_q;
    assign bus.word_elem  = elem_q;
    assign bus.word_sel   = sel_q;
    assign busy           = (state_q == SEND);
    assign overrun        = overrun_q;
`ifdef PAIRING_TRIT_CHECK_EN
    assign bad_trit       = bad_trit_q;
`endif

endmodule

// File: tb/tb_pairing_result_serializer.sv
// Directed testbench for pairing_result_serializer: basic stream, backpressure, overrun,
// reset mid-stream, coincident done edge, and (with PAIRING_TRIT_CHECK_EN) the trit flag.
module tb_pairing_result_serializer;
    localparam int W     = 32;
    localparam int WPE   = 7;
    localparam int NW    = 42;
    localparam int RES_W = 1164;

    localparam logic [193:0] O0 = 194'h1a558028a5a964224120a9212a9089a0966a0918a41612219;
    localparam logic [193:0] O5 = 194'h289898988a561125505a60640642444905248262004845aa6;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             done = 1'b0;
    logic [RES_W-1:0] result = '0;
    logic             busy;
    logic             overrun;
`ifdef PAIRING_TRIT_CHECK_EN
    logic             bad_trit;
    logic [RES_W-1:0] res3;
`endif

    int testsRun = 0;
    int testsFailed = 0;
    int lastHs;
    int nWords;
    int sawValid;

    logic [RES_W-1:0] res1;
    logic [RES_W-1:0] res2;
    logic [193:0]     o1, o2, o3, o4;
    logic [W-1:0]     gotWords [NW];

    pairing_result_serializer_if #(.WORD_W(W)) bus ();

    pairing_result_serializer #(.WORD_W(W)) dut (
        .clk     (clk),
        .reset   (reset),
        .done    (done),
        .result  (result),
        .bus     (bus),
        .busy    (busy),
        .overrun (overrun)
`ifdef PAIRING_TRIT_CHECK_EN
        ,
        .bad_trit(bad_trit)
`endif
    );

    always #5 clk = ~clk;

    // Safety net in case the DUT wedges somewhere no bounded loop covers.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference word: shift the element down, then shift the word down within the zero-padded element.
    function automatic logic [W-1:0] modelWord(input logic [RES_W-1:0] r, input int k);
        logic [RES_W-1:0] sh;
        logic [255:0]     ex;
        sh = r >> (194 * (k / WPE));
        ex = {62'b0, sh[193:0]};
        ex = ex >> (W * (k % WPE));
        return ex[W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one step after the capture edge; checks every presented word against the model and
    // optionally drops done/changes result at word lowAt and raises done at word highAt.
    task automatic applyStimulus(input int readyMode, input logic [RES_W-1:0] refRes,
                                 input int lowAt, input int highAt,
                                 input logic [RES_W-1:0] newRes,
                                 output int lastHsCycle, output int wordCount);
        int   k = 0;
        int   cyc = 1;
        int   phase = 0;
        logic rdy;
        lastHsCycle = -1;
        while (k < NW && cyc <= 400) begin
            checkOutput($sformatf("valid_w%0d", k), bus.word_valid, 1);
            checkOutput($sformatf("busy_w%0d", k), busy, 1);
            checkOutput($sformatf("word_w%0d", k), bus.word, modelWord(refRes, k));
            checkOutput($sformatf("elem_w%0d", k), bus.word_elem, k / WPE);
            checkOutput($sformatf("sel_w%0d", k), bus.word_sel, k % WPE);
            checkOutput($sformatf("last_w%0d", k), bus.word_last, (k == NW - 1));
            rdy = (readyMode == 0) || (phase == 2);
            phase = (phase + 1) % 3;
            bus.word_ready = rdy;
            if (rdy && bus.word_valid) begin
                gotWords[k] = bus.word;
                if (k == lowAt) begin
                    done = 1'b0;
                    result = newRes;
                end
                if (k == highAt) begin
                    done = 1'b1;
                end
                lastHsCycle = cyc;
                k++;
            end
            tick();
            cyc++;
        end
        bus.word_ready = 1'b1;
        wordCount = k;
    endtask

    task automatic countValid(input int cycles, output int seen);
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.word_valid) seen++;
        end
    endtask

    initial begin
        o1 = {97{2'b01}};
        o2 = {97{2'b10}};
        o3 = {O0[95:0], O5[193:96]};
        o4 = {O5[97:0], O0[193:98]};
        res1 = {O5, o4, o3, o2, o1, O0};
        res2 = {O0, o1, o2, o3, o4, O5};
        bus.word_ready = 1'b1;

        // Reset values
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", bus.word_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_overrun", overrun, 0);
        checkOutput("rst_last", bus.word_last, 0);
        checkOutput("rst_word", bus.word, 0);
        checkOutput("rst_elem", bus.word_elem, 0);
        checkOutput("rst_sel", bus.word_sel, 0);
`ifdef PAIRING_TRIT_CHECK_EN
        checkOutput("rst_bad_trit", bad_trit, 0);
`endif
        reset = 1'b1;
        result = res1;
        tick();

        // Basic stream with done held high and ready held 1
        done = 1'b1;
        tick();
        checkOutput("basic_first_valid", bus.word_valid, 1);
        applyStimulus(0, res1, -1, -1, res1, lastHs, nWords);
        checkOutput("basic_count", nWords, NW);
        checkOutput("basic_cycles", lastHs, 42);
        checkOutput("basic_word0", gotWords[0], 32'h41612219);
        checkOutput("basic_word6", gotWords[6], 32'h00000001);
        checkOutput("basic_word41", gotWords[41], 32'h00000002);
        checkOutput("basic_busy_after", busy, 0);
        checkOutput("basic_valid_after", bus.word_valid, 0);
        countValid(30, sawValid);
        checkOutput("basic_no_repeat", sawValid, 0);
`ifdef PAIRING_TRIT_CHECK_EN
        checkOutput("basic_bad_trit", bad_trit, 0);
`endif

        // Backpressure with ready pattern 0,0,1
        done = 1'b0;
        tick();
        done = 1'b1;
        tick();
        checkOutput("bp_first_valid", bus.word_valid, 1);
        applyStimulus(1, res1, -1, -1, res1, lastHs, nWords);
        checkOutput("bp_count", nWords, NW);
        checkOutput("bp_cycles", lastHs, 126);
        checkOutput("bp_busy_after", busy, 0);

        // Overrun: second done edge at word 10 with a different result on the bus
        done = 1'b0;
        tick();
        done = 1'b1;
        tick();
        checkOutput("ovr_before", overrun, 0);
        applyStimulus(0, res1, 8, 10, res2, lastHs, nWords);
        checkOutput("ovr_count", nWords, NW);
        checkOutput("ovr_flag", overrun, 1);
        checkOutput("ovr_busy_after", busy, 0);
        countValid(20, sawValid);
        checkOutput("ovr_no_second_stream", sawValid, 0);
        checkOutput("ovr_sticky", overrun, 1);

        // Reset mid-stream at word 20 with done still high
        done = 1'b0;
        result = res1;
        tick();
        done = 1'b1;
        tick();
        bus.word_ready = 1'b1;
        repeat (20) tick();
        checkOutput("mid_valid", bus.word_valid, 1);
        checkOutput("mid_word20", bus.word, modelWord(res1, 20));
        checkOutput("mid_elem", bus.word_elem, 2);
        checkOutput("mid_sel", bus.word_sel, 6);
        reset = 1'b0;
        tick();
        checkOutput("rstmid_valid", bus.word_valid, 0);
        checkOutput("rstmid_busy", busy, 0);
        checkOutput("rstmid_overrun", overrun, 0);
        reset = 1'b1;
        countValid(10, sawValid);
        checkOutput("rstmid_no_capture", sawValid, 0);

        // Coincident edge: done rises in the cycle word 41 is accepted; result changed mid-stream
        done = 1'b0;
        tick();
        done = 1'b1;
        tick();
        checkOutput("coin_first_valid", bus.word_valid, 1);
        applyStimulus(0, res1, 30, 41, res2, lastHs, nWords);
        checkOutput("coin_count", nWords, NW);
        checkOutput("coin_valid_next", bus.word_valid, 1);
        checkOutput("coin_word0_new", bus.word, modelWord(res2, 0));
        checkOutput("coin_elem0", bus.word_elem, 0);
        checkOutput("coin_overrun", overrun, 0);
        checkOutput("coin_busy", busy, 1);
        applyStimulus(0, res2, -1, -1, res2, lastHs, nWords);
        checkOutput("coin2_count", nWords, NW);
        checkOutput("coin2_valid_after", bus.word_valid, 0);

`ifdef PAIRING_TRIT_CHECK_EN
        // Illegal trit in the lowest field
        res3 = res1;
        res3[1:0] = 2'b11;
        done = 1'b0;
        result = res3;
        tick();
        done = 1'b1;
        tick();
        checkOutput("trit_bad_flag", bad_trit, 1);
        checkOutput("trit_word0", bus.word, 32'h4161221B);
        applyStimulus(0, res3, -1, -1, res3, lastHs, nWords);
        checkOutput("trit_count", nWords, NW);
        checkOutput("trit_flag_holds", bad_trit, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/pairing_result_serializer.md
Name: pairing_result_serializer

Overview:
- Downstream stage of the Duursma-Lee pairing core.
- Captures the 6-element GF(3^97) pairing result (`W6+1 = 1164 bits, six 194-bit elements o0..o5) on the rising edge of the core's done.
- Streams the result out as fixed-width words over a valid/ready interface, so the result reaches a narrow host/bus port without stalling the core.
- Single-result buffer; a new result arriving while streaming is flagged, not queued.

Parameters:
- WORD_W, 32, output word width; legal values 8, 16, 32, 64.
- WPE, ceil(194/WORD_W) (derived, localparam), words per element; 7 at default.
- NWORDS, 6*WPE (derived, localparam), words per result; 42 at default.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-low reset
- done  input  1  done from pairing core, level; a 0->1 transition marks a new result
- result  input  `W6+1  pairing output {o5,o4,o3,o2,o1,o0}; o0 = result[193:0]
- word  output  WORD_W  current output word
- word_valid  output  1  word holds valid data
- word_ready  input  1  sink accepts word this cycle
- word_last  output  1  high with the final word of a result
- word_elem  output  3  element index 0..5 of current word
- word_sel  output  3  word index within the element, 0..WPE-1
- busy  output  1  high from capture until the last word is accepted
- overrun  output  1  sticky: a result arrived while busy and was dropped

Behaviour:
- Reset (reset==0 at clk edge):
  - word_valid, busy, overrun, word_last = 0; word, word_elem, word_sel = 0; state = IDLE.
  - The done edge-detect register loads the current done, so a done held high across reset release does not trigger a capture.
  - Reset mid-stream aborts the stream immediately; remaining words are never presented.
- Capture:
  - A rising edge is detected in cycle N (done==1, done_q==0) and state==IDLE, or the final word is accepted in cycle N.
  - At the end of cycle N, result is latched into the buffer and state becomes SEND.
  - In cycle N+1: word_valid=1, busy=1, word = word 0.
- States:
  - IDLE: word_valid=0. Capture -> SEND.
  - SEND: word_valid=1. On word_valid&word_ready, advance the index. On the handshake with index NWORDS-1: go to IDLE, or stay in SEND with word 0 of the new buffer if a capture edge occurs in the same cycle.
- Word ordering:
  - Global index k = elem*WPE + sel.
  - Element e = result[194e+193 : 194e].
  - Word sel = element bits [sel*WORD_W +: WORD_W]; bits above 193 read as zero (word 6 at default carries bits 193:192 in [1:0]).
- Handshake rules:
  - word, word_elem, word_sel and word_last are stable while word_valid && !word_ready.
  - word_valid never drops without a handshake, except on reset.
  - Zero-bubble: back-to-back handshakes deliver one word per cycle, so a full result takes NWORDS cycles when word_ready is held 1.
- word_last = word_valid && (k == NWORDS-1).
- busy = (state == SEND).
- Overrun:
  - A rising done edge while SEND, other than in the final-handshake cycle, sets overrun (sticky until reset).
  - That result is discarded; the current stream continues unchanged.
- result is sampled only in the capture cycle; later changes to result are ignored.

Optional Feature:
- Macro: PAIRING_TRIT_CHECK_EN
- Defined:
  - Adds output bad_trit (1 bit, reset 0).
  - In the capture cycle, all 582 two-bit trit fields of result are checked. Encoding 2'b11 is illegal in GF(3).
  - bad_trit is loaded at the capture edge: 1 if any field is 2'b11, else 0. It holds until the next capture or reset.
  - Data is streamed unmodified regardless of the check.
- Undefined: no bad_trit port, no check logic; all other behaviour identical.

Test Plan:
- Basic stream:
  - Stimulus: reset 0 for 2 cycles, then 1. result = {o5..o0} with o0 = 194'h1a558028a5a964224120a9212a9089a0966a0918a41612219 and o5 = 194'h289898988a561125505a60640642444905248262004845aa6. Raise done and hold it high; hold word_ready = 1.
  - Required: first word 32'h41612219 with elem 0, sel 0, one cycle after the done edge. Word 6 = 32'h00000001. Word 41 = 32'h00000002 with word_last = 1. busy falls the cycle after. Exactly 42 words, no repeat while done stays high.
- Backpressure:
  - Stimulus: word_ready toggles 0,0,1 repeatedly.
  - Required: word, word_elem and word_sel stay stable while stalled. The sequence equals the basic case. Total 126 cycles from first valid to last handshake.
- Overrun:
  - Stimulus: second done pulse at word 10.
  - Required: overrun = 1 and stays 1. Stream continues to word 41 with the original data. busy drops afterwards; no second stream.
- Coincident edge:
  - Stimulus: done rises in the same cycle word 41 is accepted.
  - Required: next cycle word_valid = 1 with word 0 of the new result; overrun stays 0.
- Reset:
  - Stimulus: reset = 0 at word 20 while done is still high, then release.
  - Required: word_valid = 0 and busy = 0 in the next cycle; no capture after release until done goes 0 then 1.
- Trit check (PAIRING_TRIT_CHECK_EN defined):
  - Stimulus: the basic result gives bad_trit = 0. Then force result[1:0] = 2'b11 and pulse done.
  - Required: bad_trit = 1, and word 0 = 32'h4161221B.
